// File: rtl/fc_acc_ctrl.sv
// ---------------------------------------------------------------------------
// fc_acc_ctrl
//
// Sequencer for the 10-lane FC register-accumulator bank of the output layer.
// A pass loads the bias into every lane, streams NUM_INPUTS feature/weight
// addresses, and raises enable_write once per accepted feature, MAC_LATENCY
// cycles after it was transferred. This lines enable_write up with the
// multiplier pipeline. done then holds until the consumer acknowledges.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        1-cycle request to run one pass (only taken in IDLE)
//   feat_valid   feature buffer holds the word addressed by feat_addr
//   result_ack   consumer has taken the accumulator outputs; releases done
//   feat_rd      read strobe to the feature buffer (transfer = feat_rd & feat_valid)
//   feat_addr    feature index being read
//   weight_addr  weight ROM row, always equal to feat_addr
//   bias_sel     bias load into all lanes (one cycle per pass)
//   enable_write accumulate strobe to all lanes
//   busy         high in BIAS, ISSUE and DRAIN
//   done         accumulator outputs are final; held until result_ack
// ---------------------------------------------------------------------------
module fc_acc_ctrl #(
    parameter int unsigned NUM_INPUTS  = 84,
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned MAC_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  feat_valid,
    input  logic                  result_ack,
    output logic                  feat_rd,
    output logic [ADDR_WIDTH-1:0] feat_addr,
    output logic [ADDR_WIDTH-1:0] weight_addr,
    output logic                  bias_sel,
    output logic                  enable_write,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_INPUTS - 1);
    localparam logic [DRAIN_W-1:0]    LAST_DRAIN = DRAIN_W'(MAC_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [DRAIN_W-1:0]     drain_q, drain_d;
    // Bit i set means a transfer happened i+1 cycles ago; the MSB is the
    // accumulate strobe for the data now arriving at the lanes.
    logic [MAC_LATENCY-1:0] pipe_q, pipe_d;
    logic                   push;

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        push     = 1'b0;
        feat_rd  = 1'b0;
        bias_sel = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Clearing here makes the address read 0 during BIAS.
                if (start) begin
                    state_d = ST_BIAS;
                    idx_d   = '0;
                end
            end

            ST_BIAS: begin
                bias_sel = 1'b1;
                idx_d    = '0;
                state_d  = ST_ISSUE;
            end

            ST_ISSUE: begin
                feat_rd = feat_valid;
                drain_d = '0;
                if (feat_valid) begin
                    push = 1'b1;
                    // The index stops at the last address so it holds that
                    // value for the rest of the pass and while idle.
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + ADDR_WIDTH'(1);
                    end
                end
            end

            ST_DRAIN: begin
                // The last strobe leaves the pipe on the final DRAIN cycle.
                if (drain_q == LAST_DRAIN) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end

            ST_DONE: begin
                // start in this state is dropped, even alongside result_ack.
                if (result_ack) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pipe_d = MAC_LATENCY'({pipe_q, push});
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            drain_q <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            pipe_q  <= pipe_d;
        end
    end

    assign feat_addr    = idx_q;
    assign weight_addr  = idx_q;
    assign enable_write = pipe_q[MAC_LATENCY-1];
    assign busy         = (state_q == ST_BIAS) || (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_fc_acc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fc_acc_ctrl
//
// Bench for fc_acc_ctrl with NUM_INPUTS=4, MAC_LATENCY=2. The reference model
// reasons in events: the features transferred so far, the cycle of each
// transfer, and strobes due MAC_LATENCY cycles later. A 10-lane accumulator
// model fed from a feature buffer (word i holds i+1) checks the final sums.
// ---------------------------------------------------------------------------
module tb_fc_acc_ctrl;

    localparam int N        = 4;
    localparam int AW       = 3;
    localparam int L        = 2;
    localparam int BIAS     = 5;
    localparam int EXP_LANE = BIAS + N * (N + 1) / 2;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          start      = 1'b0;
    logic          feat_valid = 1'b0;
    logic          result_ack = 1'b0;
    logic          feat_rd;
    logic [AW-1:0] feat_addr;
    logic [AW-1:0] weight_addr;
    logic          bias_sel;
    logic          enable_write;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    int acc[10];
    int data_q[$];

    always #5 clk = ~clk;

    fc_acc_ctrl #(
        .NUM_INPUTS (N),
        .ADDR_WIDTH (AW),
        .MAC_LATENCY(L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .feat_valid  (feat_valid),
        .result_ack  (result_ack),
        .feat_rd     (feat_rd),
        .feat_addr   (feat_addr),
        .weight_addr (weight_addr),
        .bias_sel    (bias_sel),
        .enable_write(enable_write),
        .busy        (busy),
        .done        (done)
    );

    // Output bundle: {feat_rd, feat_addr, weight_addr, bias_sel, enable_write, busy, done}
    wire [10:0] obs = {feat_rd, feat_addr, weight_addr, bias_sel, enable_write, busy, done};

    function automatic logic [10:0] pack_exp(input bit rd, input int addr, input bit bs,
                                             input bit ew, input bit bz, input bit dn);
        return {rd, AW'(addr), AW'(addr), bs, ew, bz, dn};
    endfunction

    // Accumulator bank and feature buffer model, advanced once per cycle.
    task automatic sb_sample();
        if (bias_sel) begin
            foreach (acc[i]) acc[i] = BIAS;
        end
        if (enable_write && data_q.size() > 0) begin
            int d;
            d = data_q.pop_front();
            foreach (acc[i]) acc[i] += d;
        end
        if (feat_rd && feat_valid) data_q.push_back(int'(feat_addr) + 1);
    endtask

    // One full pass: start, issue with the chosen feat_valid pattern, done
    // hold, acknowledge. mode 0 = no stalls, 1 = stalls at t3/t4, 2 = random.
    task automatic run_pass(input string name, input int mode, input int hold,
                            input bit start_in_issue, input bit start_in_done,
                            input bit start_with_ack, output int done_cyc);
        bit         ew_sched[256];
        int         n;
        int         last_tr;
        int         ew_seen;
        bit         fv;
        bit         exp_rd;
        bit         exp_done;
        int         exp_addr;
        logic [10:0] exp;

        n        = 0;
        last_tr  = -100;
        ew_seen  = 0;
        done_cyc = -1;
        data_q.delete();
        foreach (acc[i]) acc[i] = 0;
        foreach (ew_sched[i]) ew_sched[i] = 1'b0;

        // t0: request
        @(posedge clk); #1;
        start = 1'b1; feat_valid = 1'b0; result_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({bias_sel, enable_write, busy, done, feat_rd} !== 5'b0) begin
            errors++;
            $display("FAIL %s t0_idle: got %b expected 00000", name,
                     {bias_sel, enable_write, busy, done, feat_rd});
        end

        // t1: bias load
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        exp = pack_exp(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t1_bias: got %b expected %b", name, obs, exp);
        end
        sb_sample();

        // t2 onward: issue, drain, first done cycle
        for (int cyc = 2; cyc < 200; cyc++) begin
            @(posedge clk); #1;
            if (n < N) begin
                case (mode)
                    0:       fv = 1'b1;
                    1:       fv = !(cyc == 3 || cyc == 4);
                    default: fv = ($urandom_range(0, 3) != 0);
                endcase
            end else begin
                fv = 1'($urandom_range(0, 1));
            end
            feat_valid = fv;
            start      = start_in_issue && (cyc == 3);
            @(negedge clk);
            exp_rd   = (n < N) && fv;
            exp_addr = (n < N) ? n : N - 1;
            exp_done = (n == N) && (cyc > last_tr + L);
            exp = pack_exp(exp_rd, exp_addr, 1'b0, ew_sched[cyc], !exp_done, exp_done);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s t%0d: got %b expected %b", name, cyc, obs, exp);
            end
            if (enable_write === 1'b1) ew_seen++;
            sb_sample();
            if (exp_rd) begin
                n++;
                last_tr = cyc;
                ew_sched[cyc + L] = 1'b1;
            end
            if (exp_done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;

        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL %s timeout: done not expected within 200 cycles", name);
            return;
        end

        checks++;
        if (ew_seen != N) begin
            errors++;
            $display("FAIL %s ew_count: got %0d expected %0d", name, ew_seen, N);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (acc[i] != EXP_LANE) begin
                errors++;
                $display("FAIL %s lane%0d: got %0d expected %0d", name, i, acc[i], EXP_LANE);
            end
        end

        // done held, start possibly pulsed, no ack yet
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            start      = start_in_done && (h == 1);
            feat_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp = pack_exp(1'b0, N - 1, 1'b0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s hold%0d: got %b expected %b", name, h, obs, exp);
            end
        end

        // ack cycle: still DONE
        @(posedge clk); #1;
        start = start_with_ack; result_ack = 1'b1;
        @(negedge clk);
        exp = pack_exp(1'b0, N - 1, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s ack_cycle: got %b expected %b", name, obs, exp);
        end

        // two idle cycles: done released, no new pass started
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            start = 1'b0; result_ack = 1'b0;
            @(negedge clk);
            exp = pack_exp(1'b0, N - 1, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s idle%0d: got %b expected %b", name, k, obs, exp);
            end
        end
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        reset = 1'b0; start = 1'b0; feat_valid = 1'b0; result_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp = pack_exp(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, exp);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obs, exp);
        end

        // run into ISSUE with idx=2, then abort asynchronously
        @(posedge clk); #1;
        start = 1'b1; feat_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        exp = pack_exp(1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_pre_abort: got %b expected %b", obs, exp);
        end
        #1 reset = 1'b0;
        #1;
        exp = pack_exp(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", obs, exp);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_after%0d: got %b expected %b", k, obs, exp);
            end
        end
        feat_valid = 1'b0;
    endtask

    task automatic test_clean();
        int dc;
        run_pass("clean", 0, 10, 1'b0, 1'b0, 1'b0, dc);
        checks++;
        if (dc != 8) begin
            errors++;
            $display("FAIL clean_done_time: got t%0d expected t8", dc);
        end
    endtask

    task automatic test_stalls();
        int dc;
        run_pass("stall", 1, 3, 1'b0, 1'b0, 1'b0, dc);
        checks++;
        if (dc != 10) begin
            errors++;
            $display("FAIL stall_done_time: got t%0d expected t10", dc);
        end
    endtask

    task automatic test_ignored();
        int dc;
        logic [10:0] exp;
        // result_ack while idle changes nothing
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            result_ack = 1'b1;
            @(negedge clk);
            exp = pack_exp(1'b0, N - 1, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ack_in_idle%0d: got %b expected %b", k, obs, exp);
            end
        end
        result_ack = 1'b0;
        run_pass("ignored_start", 0, 4, 1'b1, 1'b1, 1'b0, dc);
        checks++;
        if (dc != 8) begin
            errors++;
            $display("FAIL ignored_done_time: got t%0d expected t8", dc);
        end
    endtask

    task automatic test_done_edges();
        int dc;
        run_pass("ack_with_start", 0, 2, 1'b0, 1'b0, 1'b1, dc);
        run_pass("fresh_after_ack", 0, 1, 1'b0, 1'b0, 1'b0, dc);
        checks++;
        if (dc != 8) begin
            errors++;
            $display("FAIL fresh_done_time: got t%0d expected t8", dc);
        end
    endtask

    task automatic test_random();
        int dc;
        for (int p = 0; p < 6; p++) begin
            run_pass($sformatf("random%0d", p), 2, 2 + $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), dc);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_stalls();
        test_ignored();
        test_done_edges();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
